// File: rtl/x87_issue_seq.sv
// Issue sequencer between the integer pipeline and the x87 FPU wrapper.
// Handles one instruction at a time: operand load, FPU start/run, optional store, retire.
module x87_issue_seq #(
    parameter int MAX_STEP = 15,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [7:0]  issue_op1,
    input  logic [7:0]  issue_op2,
    input  logic        issue_op2_valid,
    input  logic [1:0]  issue_load_size,
    output logic        mem_rd_req,
    output logic [1:0]  mem_rd_size,
    input  logic        mem_rd_ack,
    input  logic [63:0] mem_rd_data,
    output logic        fpu_start,
    output logic [7:0]  fpu_op1,
    output logic [7:0]  fpu_op2,
    output logic        fpu_op2_valid,
    output logic [3:0]  fpu_step,
    output logic [31:0] fpu_mem_rdata32,
    output logic [63:0] fpu_mem_rdata64,
    input  logic        fpu_busy,
    input  logic        fpu_done,
    input  logic        fpu_wb_valid,
    input  logic [2:0]  fpu_wb_kind,
    input  logic [15:0] fpu_wb_value,
    input  logic        fpu_memstore_valid,
    input  logic [1:0]  fpu_memstore_size,
    input  logic [63:0] fpu_memstore_data64,
    output logic        mem_wr_req,
    output logic [1:0]  mem_wr_size,
    output logic [63:0] mem_wr_data,
    input  logic        mem_wr_ack,
    output logic        retire_valid,
    output logic        retire_wb_valid,
    output logic [2:0]  retire_wb_kind,
    output logic [15:0] retire_wb_value,
    output logic        retire_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, STORE, RETIRE} state_t;

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      STEP_MAX = 4'(MAX_STEP);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [CW-1:0] tmo_cnt;
    logic          accept, run_tmo, store_seen;
    logic          ready_d, rd_req_d, start_d, wr_req_d, retire_d;
    logic          wb_flag, wb_flag_d, st_flag, st_flag_d;
    logic [2:0]    wb_kind, wb_kind_d;
    logic [15:0]   wb_value, wb_value_d;
    logic [1:0]    st_size_d;
    logic [63:0]   st_data_d;
    logic          unused_busy;

    // fpu_busy is informational only; it never steers the sequencer.
    assign unused_busy = fpu_busy;

    assign accept     = (state == IDLE) && issue_ready && issue_valid;
    assign run_tmo    = (state == RUN) && !fpu_done && (tmo_cnt == CNT_LAST);
    assign store_seen = st_flag || fpu_memstore_valid;
    assign fpu_mem_rdata32 = fpu_mem_rdata64[31:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state;
        case (state)
            IDLE:    if (accept)
                         state_d = (issue_load_size == 2'd1 || issue_load_size == 2'd2) ? LOAD : START;
            LOAD:    if (mem_rd_ack) state_d = START;
            START:   state_d = RUN;
            RUN:     if (fpu_done)     state_d = store_seen ? STORE : RETIRE;
                     else if (run_tmo) state_d = RETIRE;
            STORE:   if (mem_wr_ack) state_d = RETIRE;
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so they line up with the state register.
    always_comb begin
        ready_d    = (state_d == IDLE);
        rd_req_d   = (state_d == LOAD);
        start_d    = (state_d == START);
        wr_req_d   = (state_d == STORE);
        retire_d   = (state_d == RETIRE);
        wb_flag_d  = wb_flag;
        wb_kind_d  = wb_kind;
        wb_value_d = wb_value;
        st_flag_d  = st_flag;
        st_size_d  = mem_wr_size;
        st_data_d  = mem_wr_data;
        if (accept) begin
            wb_flag_d  = 1'b0;
            wb_kind_d  = '0;
            wb_value_d = '0;
            st_flag_d  = 1'b0;
            st_size_d  = '0;
            st_data_d  = '0;
        end else if (state == RUN) begin
            if (fpu_wb_valid) begin
                wb_flag_d  = 1'b1;
                wb_kind_d  = fpu_wb_kind;
                wb_value_d = fpu_wb_value;
            end
            if (fpu_memstore_valid) begin
                st_flag_d = 1'b1;
                st_size_d = fpu_memstore_size;
                st_data_d = fpu_memstore_data64;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            issue_ready     <= 1'b0;
            mem_rd_req      <= 1'b0;
            fpu_start       <= 1'b0;
            mem_wr_req      <= 1'b0;
            retire_valid    <= 1'b0;
            mem_rd_size     <= '0;
            fpu_op1         <= '0;
            fpu_op2         <= '0;
            fpu_op2_valid   <= 1'b0;
            fpu_step        <= '0;
            fpu_mem_rdata64 <= '0;
            tmo_cnt         <= '0;
            wb_flag         <= 1'b0;
            wb_kind         <= '0;
            wb_value        <= '0;
            st_flag         <= 1'b0;
            mem_wr_size     <= '0;
            mem_wr_data     <= '0;
            retire_wb_valid <= 1'b0;
            retire_wb_kind  <= '0;
            retire_wb_value <= '0;
            retire_timeout  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_d;
            issue_ready  <= ready_d;
            mem_rd_req   <= rd_req_d;
            fpu_start    <= start_d;
            mem_wr_req   <= wr_req_d;
            retire_valid <= retire_d;
            wb_flag      <= wb_flag_d;
            wb_kind      <= wb_kind_d;
            wb_value     <= wb_value_d;
            st_flag      <= st_flag_d;
            mem_wr_size  <= st_size_d;
            mem_wr_data  <= st_data_d;
            if (accept) begin
                fpu_op1       <= issue_op1;
                fpu_op2       <= issue_op2;
                fpu_op2_valid <= issue_op2_valid;
                mem_rd_size   <= issue_load_size;
            end
            if (state == LOAD && mem_rd_ack)
                fpu_mem_rdata64 <= (mem_rd_size == 2'd1) ? {32'h0, mem_rd_data[31:0]} : mem_rd_data;
            if (state_d == START)
                fpu_step <= '0;
            else if (state == RUN && state_d == RUN && fpu_step != STEP_MAX)
                fpu_step <= fpu_step + 4'd1;
            if (state == START)
                tmo_cnt <= '0;
            else if (state == RUN)
                tmo_cnt <= tmo_cnt + CW'(1);
            if (state_d == RETIRE) begin
                retire_wb_valid <= wb_flag_d;
                retire_wb_kind  <= wb_kind_d;
                retire_wb_value <= wb_value_d;
                retire_timeout  <= run_tmo;
            end
        end
    end

endmodule

// File: tb/tb_x87_issue_seq.sv
// Self-checking bench for x87_issue_seq: directed scenarios plus randomized
// transactions scored against a transaction-level timeline model.
module tb_x87_issue_seq;

    localparam int MAX_STEP = 15;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_ready, issue_op2_valid;
    logic [7:0]  issue_op1, issue_op2;
    logic [1:0]  issue_load_size;
    logic        mem_rd_req, mem_rd_ack;
    logic [1:0]  mem_rd_size;
    logic [63:0] mem_rd_data;
    logic        fpu_start, fpu_op2_valid;
    logic [7:0]  fpu_op1, fpu_op2;
    logic [3:0]  fpu_step;
    logic [31:0] fpu_mem_rdata32;
    logic [63:0] fpu_mem_rdata64;
    logic        fpu_busy, fpu_done, fpu_wb_valid, fpu_memstore_valid;
    logic [2:0]  fpu_wb_kind;
    logic [15:0] fpu_wb_value;
    logic [1:0]  fpu_memstore_size;
    logic [63:0] fpu_memstore_data64;
    logic        mem_wr_req, mem_wr_ack;
    logic [1:0]  mem_wr_size;
    logic [63:0] mem_wr_data;
    logic        retire_valid, retire_wb_valid, retire_timeout;
    logic [2:0]  retire_wb_kind;
    logic [15:0] retire_wb_value;

    int n_cmp = 0;
    int n_err = 0;

    // Model state that persists across instructions
    logic [63:0] m_rdata;
    logic        m_wbv, m_tmo;
    logic [2:0]  m_kind;
    logic [15:0] m_val;

    x87_issue_seq #(.MAX_STEP(MAX_STEP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_op2_valid(issue_op2_valid), .issue_load_size(issue_load_size),
        .mem_rd_req(mem_rd_req), .mem_rd_size(mem_rd_size),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
        .fpu_start(fpu_start), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
        .fpu_op2_valid(fpu_op2_valid), .fpu_step(fpu_step),
        .fpu_mem_rdata32(fpu_mem_rdata32), .fpu_mem_rdata64(fpu_mem_rdata64),
        .fpu_busy(fpu_busy), .fpu_done(fpu_done),
        .fpu_wb_valid(fpu_wb_valid), .fpu_wb_kind(fpu_wb_kind), .fpu_wb_value(fpu_wb_value),
        .fpu_memstore_valid(fpu_memstore_valid), .fpu_memstore_size(fpu_memstore_size),
        .fpu_memstore_data64(fpu_memstore_data64),
        .mem_wr_req(mem_wr_req), .mem_wr_size(mem_wr_size),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
        .retire_valid(retire_valid), .retire_wb_valid(retire_wb_valid),
        .retire_wb_kind(retire_wb_kind), .retire_wb_value(retire_wb_value),
        .retire_timeout(retire_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives every input; with noise, inputs get random values the DUT must ignore.
    task automatic drive_inputs(input bit noise);
        issue_valid         = noise ? 1'($urandom) : 1'b0;
        issue_op1           = 8'($urandom);
        issue_op2           = 8'($urandom);
        issue_op2_valid     = 1'($urandom);
        issue_load_size     = 2'($urandom);
        mem_rd_ack          = noise ? 1'($urandom) : 1'b0;
        mem_rd_data         = {$urandom, $urandom};
        fpu_busy            = 1'($urandom);
        fpu_done            = noise ? 1'($urandom) : 1'b0;
        fpu_wb_valid        = noise ? 1'($urandom) : 1'b0;
        fpu_wb_kind         = 3'($urandom);
        fpu_wb_value        = 16'($urandom);
        fpu_memstore_valid  = noise ? 1'($urandom) : 1'b0;
        fpu_memstore_size   = 2'($urandom);
        fpu_memstore_data64 = {$urandom, $urandom};
        mem_wr_ack          = noise ? 1'($urandom) : 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_ctl", tag), {issue_ready, mem_rd_req, fpu_start, mem_wr_req, retire_valid,
              retire_wb_valid, retire_timeout, fpu_op2_valid}, 64'h0);
        check($sformatf("%s_fields", tag), {mem_rd_size, mem_wr_size, fpu_step, retire_wb_kind,
              fpu_op1, fpu_op2, retire_wb_value}, 64'h0);
        check($sformatf("%s_rdata64", tag), fpu_mem_rdata64, 64'h0);
        check($sformatf("%s_rdata32", tag), fpu_mem_rdata32, 64'h0);
        check($sformatf("%s_wrdata", tag), mem_wr_data, 64'h0);
    endtask

    task automatic check_retire_fields(input string tag);
        check($sformatf("%s_wbv", tag), retire_wb_valid, m_wbv);
        check($sformatf("%s_kind", tag), retire_wb_kind, m_kind);
        check($sformatf("%s_val", tag), retire_wb_value, m_val);
        check($sformatf("%s_tmo", tag), retire_timeout, m_tmo);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", issue_ready, 1'b1);
            check("idle_retire", retire_valid, 1'b0);
            check_retire_fields("idle_hold");
            drive_inputs(1'b1);
            issue_valid = 1'b0;
        end
    endtask

    // One instruction. The expected timeline comes from the phase lengths:
    // optional LOAD of rd_d cycles, one START, e RUN cycles, optional STORE of wr_w, one RETIRE.
    task automatic run_op(input logic [7:0] op1, input logic [7:0] op2, input logic op2v,
                          input logic [1:0] lsize, input int rd_d, input logic [63:0] rdata,
                          input int done_k, input int wr_w, input bit noise,
                          input int wb_k, input logic [2:0] wb_kind_f, input logic [15:0] wb_val_f,
                          input int ms_k, input logic [1:0] ms_size_f, input logic [63:0] ms_data_f);
        bit          has_load, timed_out, do_store, any_wb, any_ms;
        bit          in_load, in_start, in_run, in_store, in_ret, in_idle;
        int          s, e, ret, li, ri, si;
        logic        wbv [1:TIMEOUT];
        logic [2:0]  wk  [1:TIMEOUT];
        logic [15:0] wv  [1:TIMEOUT];
        logic        msv [1:TIMEOUT];
        logic [1:0]  mss [1:TIMEOUT];
        logic [63:0] msd [1:TIMEOUT];
        logic [2:0]  exp_kind;
        logic [15:0] exp_val;
        logic [1:0]  exp_ss;
        logic [63:0] exp_sd;

        has_load  = (lsize == 2'd1) || (lsize == 2'd2);
        s         = has_load ? rd_d + 1 : 1;
        timed_out = (done_k < 1) || (done_k > TIMEOUT);
        e         = timed_out ? TIMEOUT : done_k;
        any_wb = 0; any_ms = 0; exp_kind = '0; exp_val = '0; exp_ss = '0; exp_sd = '0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            wbv[k] = noise && ($urandom_range(0, 2) == 0);
            wk[k]  = 3'($urandom);
            wv[k]  = 16'($urandom);
            msv[k] = noise && ($urandom_range(0, 4) == 0);
            mss[k] = 2'($urandom);
            msd[k] = {$urandom, $urandom};
            if (k == wb_k) begin wbv[k] = 1'b1; wk[k] = wb_kind_f; wv[k] = wb_val_f; end
            if (k == ms_k) begin msv[k] = 1'b1; mss[k] = ms_size_f; msd[k] = ms_data_f; end
            if (k <= e && wbv[k]) begin any_wb = 1; exp_kind = wk[k]; exp_val = wv[k]; end
            if (k <= e && msv[k]) begin any_ms = 1; exp_ss = mss[k]; exp_sd = msd[k]; end
        end
        do_store = !timed_out && any_ms;
        ret      = s + e + (do_store ? wr_w : 0) + 1;
        if (lsize == 2'd1)      m_rdata = {32'h0, rdata[31:0]};
        else if (lsize == 2'd2) m_rdata = rdata;

        @(negedge clk);
        check("accept_ready", issue_ready, 1'b1);
        drive_inputs(noise);
        issue_valid = 1'b1; issue_op1 = op1; issue_op2 = op2;
        issue_op2_valid = op2v; issue_load_size = lsize;

        for (int c = 1; c <= ret + 1; c++) begin
            @(negedge clk);
            li = c; ri = c - s; si = c - s - e;
            in_load  = has_load && c <= rd_d;
            in_start = (c == s);
            in_run   = (ri >= 1) && (ri <= e);
            in_store = do_store && (si >= 1) && (si <= wr_w);
            in_ret   = (c == ret);
            in_idle  = (c == ret + 1);
            check("ready", issue_ready, in_idle);
            check("rd_req", mem_rd_req, in_load);
            check("start", fpu_start, in_start);
            check("wr_req", mem_wr_req, in_store);
            check("retire", retire_valid, in_ret);
            if (in_load) check("rd_size", mem_rd_size, lsize);
            if (in_start) begin
                check("op1", fpu_op1, op1);
                check("op2", fpu_op2, op2);
                check("op2v", fpu_op2_valid, op2v);
                check("step_start", fpu_step, 0);
                check("rdata64", fpu_mem_rdata64, m_rdata);
                check("rdata32", fpu_mem_rdata32, m_rdata[31:0]);
            end
            if (in_run) check("step_run", fpu_step, (ri - 1 > MAX_STEP) ? MAX_STEP : ri - 1);
            if (in_store) begin
                check("wr_size", mem_wr_size, exp_ss);
                check("wr_data", mem_wr_data, exp_sd);
            end
            if (in_ret) begin
                m_wbv = any_wb; m_kind = exp_kind; m_val = exp_val; m_tmo = timed_out;
            end
            if (in_ret || in_idle) check_retire_fields(in_ret ? "ret" : "ret_hold");

            drive_inputs(noise);
            if (in_idle) issue_valid = 1'b0;
            if (in_load) begin
                mem_rd_ack = (li == rd_d);
                if (li == rd_d) mem_rd_data = rdata;
            end
            if (in_run) begin
                fpu_done            = (ri == done_k);
                fpu_wb_valid        = wbv[ri];
                fpu_wb_kind         = wk[ri];
                fpu_wb_value        = wv[ri];
                fpu_memstore_valid  = msv[ri];
                fpu_memstore_size   = mss[ri];
                fpu_memstore_data64 = msd[ri];
            end
            if (in_store) mem_wr_ack = (si == wr_w);
        end
    endtask

    task automatic reset_in_load;
        @(negedge clk);
        check("rl_ready", issue_ready, 1'b1);
        drive_inputs(1'b0);
        issue_valid = 1'b1; issue_op1 = 8'hDD; issue_op2 = 8'h05;
        issue_op2_valid = 1'b1; issue_load_size = 2'd2;
        @(negedge clk);
        check("rl_req1", mem_rd_req, 1'b1);
        drive_inputs(1'b0);
        @(negedge clk);
        check("rl_req2", mem_rd_req, 1'b1);
        check("rl_size", mem_rd_size, 2'd2);
        #2 rst = 1'b1;
        #1 check_all_zero("rl_async");
        @(negedge clk);
        check_all_zero("rl_hold");
        rst = 1'b0;
        m_rdata = '0; m_wbv = 1'b0; m_kind = '0; m_val = '0; m_tmo = 1'b0;
        @(negedge clk);
        check("rl_ready_after", issue_ready, 1'b1);
        check("rl_req_after", mem_rd_req, 1'b0);
        check("rl_retire_after", retire_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_rdata = '0; m_wbv = 1'b0; m_kind = '0; m_val = '0; m_tmo = 1'b0;
        drive_inputs(1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // No-operand op, done in RUN cycle 3 with writeback
        run_op(8'hD9, 8'hE8, 1'b1, 2'd0, 1, 64'h0, 3, 1, 1'b0, 3, 3'd2, 16'h1234, 0, 2'd0, 64'h0);
        // 32-bit load, ack on 4th LOAD cycle
        run_op(8'hD9, 8'h06, 1'b1, 2'd1, 4, 64'hFFFF_FFFF_3F80_0000, 2, 1, 1'b0, 0, 3'd0, 16'h0, 0, 2'd0, 64'h0);
        // 64-bit load
        run_op(8'hDD, 8'h06, 1'b1, 2'd2, 1, 64'h8123_4567_89AB_CDEF, 1, 1, 1'b0, 1, 3'd5, 16'hBEEF, 0, 2'd0, 64'h0);
        // 64-bit store requested in the done cycle, ack two cycles late
        idle_cycles(2);
        run_op(8'hDD, 8'h1E, 1'b1, 2'd0, 1, 64'h0, 5, 3, 1'b0, 0, 3'd0, 16'h0, 5, 2'd2, 64'h4009_21FB_5444_2D18);
        // Step saturation, done in RUN cycle 21
        run_op(8'hD9, 8'hFA, 1'b0, 2'd0, 1, 64'h0, 21, 1, 1'b0, 0, 3'd0, 16'h0, 0, 2'd0, 64'h0);
        // Timeout with a store seen: store dropped
        run_op(8'hD9, 8'hF1, 1'b1, 2'd0, 1, 64'h0, 0, 1, 1'b0, 4, 3'd1, 16'h00AA, 10, 2'd1, 64'h1111_2222_3333_4444);
        idle_cycles(1);
        // Done on the last RUN cycle before timeout wins
        run_op(8'hD9, 8'hF2, 1'b1, 2'd0, 1, 64'h0, TIMEOUT, 2, 1'b0, 0, 3'd0, 16'h0, TIMEOUT, 2'd3, 64'hCAFE_F00D_0000_0001);
        // Reserved load size behaves as none
        run_op(8'hDB, 8'h2D, 1'b1, 2'd3, 1, 64'h0, 2, 1, 1'b1, 0, 3'd0, 16'h0, 0, 2'd0, 64'h0);
        // Reset during LOAD, then a normal instruction
        reset_in_load();
        run_op(8'hD8, 8'hC1, 1'b1, 2'd1, 2, 64'h0BAD_0BAD_4048_F5C3, 4, 1, 1'b0, 2, 3'd3, 16'h5A5A, 0, 2'd0, 64'h0);

        for (int t = 0; t < 40; t++) begin
            int dk;
            dk = ($urandom_range(0, 7) == 0) ? 0 :
                 ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT) :
                 $urandom_range(1, 24);
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), $urandom_range(1, 5),
                   {$urandom, $urandom}, dk, $urandom_range(1, 4), 1'b1,
                   0, 3'd0, 16'h0, 0, 2'd0, 64'h0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
